// File: rtl/grf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wport_arbiter
//
// Purpose:
//   Owns the single write port of the general register file. Two sources share
//   it: the in-order writeback stage (W) and an auxiliary late-result requester
//   (multi-cycle MDU, delayed load path). Aux results go into a small in-order
//   queue and drain into cycles where W does not write. A starvation counter
//   freezes the pipeline if a queued result has waited too long. A younger W
//   write to the same register cancels any older queued write (WAW kill). The
//   hazard unit can ask whether a register still has a live queued write.
//
// Parameters:
//   DEPTH      - aux queue entries (power of 2, >= 2)
//   STARVE_MAX - cycles a queue head may wait before pipe_stall is raised
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (0 = reset)
//   w_we       in   writeback-stage write enable
//   w_adr      in   writeback-stage destination register
//   w_wd       in   writeback-stage write data
//   w_pc       in   writeback-stage instruction PC
//   aux_valid  in   aux result offered
//   aux_ready  out  aux result accepted this cycle (= !full)
//   aux_adr    in   aux destination register
//   aux_wd     in   aux data
//   aux_pc     in   PC of the producing instruction
//   q_adr1/2   in   hazard query registers
//   q_hit1/2   out  query register has a live queued write
//   pipe_stall out  freeze request to the pipeline (holds the W stage)
//   grf_we     out  GRF write enable
//   grf_adr    out  GRF write address
//   grf_wd     out  GRF write data
//   grf_pc     out  PC of the instruction being committed
//
// Handshake:
//   An aux result is transferred on a rising edge where aux_valid && aux_ready.
//   aux_ready depends only on queue occupancy, never on aux_valid, so the
//   producer may hold aux_valid and wait.
//
// Optional feature:
//   GRF_WPORT_TRACE_EN - when defined, a simulation-only trace line
//   "@<pc>: $<adr> <= <data>" is printed on every edge where grf_we is 1.
//   When undefined no trace code is compiled.
// -----------------------------------------------------------------------------
module grf_wport_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_adr,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_adr,
    input  logic [31:0] aux_wd,
    input  logic [31:0] aux_pc,
    input  logic [4:0]  q_adr1,
    input  logic [4:0]  q_adr2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic        pipe_stall,
    output logic        grf_we,
    output logic [4:0]  grf_adr,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // ------------------------------------------------------------------------
    // Queue storage and control state
    // ------------------------------------------------------------------------
    logic [4:0]       adr_q [DEPTH];
    logic [31:0]      wd_q  [DEPTH];
    logic [31:0]      pc_q  [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q,  stall_d;

    logic             empty;
    logic             full;
    logic             w_eff;
    logic             pop;
    logic             push;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // While the pipeline is frozen the W stage is held upstream, so its write
    // is ignored here and retried once the stall drops.
    assign w_eff = w_we && (w_adr != 5'd0) && !stall_q;

    // The head drains whenever W leaves the port idle.
    assign pop  = !w_eff && !empty;
    assign push = aux_valid && !full;

    assign aux_ready  = !full;
    assign pipe_stall = stall_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Live bits only exist for occupied slots: a pop clears the head bit, so
    // q_hit never needs to consult the pointers. Order matters: the WAW kill
    // is applied before the enqueue so an entry accepted at the same edge as
    // a W write to its register (which is younger) survives.
    always_comb begin
        live_d = live_q;
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (w_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adr_q[i] == w_adr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            // A write to $0 is accepted but drains as a no-op.
            live_d[wr_ptr_q] = (aux_adr != 5'd0);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation: count cycles the head sits undrained, saturating at the
    // limit. Once at the limit the stall flop sets; it stays set until the
    // queue has fully drained, which bounds the stall by the queue depth
    // when no further aux results arrive.
    always_comb begin
        if (pop || empty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        if (count_d == '0) begin
            stall_d = 1'b0;
        end else if (starve_q == STARVE_LIM) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload needs no reset: a slot is only read while occupied, and
    // occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[wr_ptr_q] <= aux_adr;
            wd_q[wr_ptr_q]  <= aux_wd;
            pc_q[wr_ptr_q]  <= aux_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Write-port mux. W has zero latency; the head entry is shown whenever W
    // is idle, with grf_we following its live bit. Reset forces the port
    // quiet immediately, including against an active W request.
    // ------------------------------------------------------------------------
    always_comb begin
        grf_we  = 1'b0;
        grf_adr = 5'd0;
        grf_wd  = 32'd0;
        grf_pc  = 32'd0;
        if (reset) begin
            if (w_eff) begin
                grf_we  = 1'b1;
                grf_adr = w_adr;
                grf_wd  = w_wd;
                grf_pc  = w_pc;
            end else if (!empty) begin
                grf_we  = live_q[rd_ptr_q];
                grf_adr = adr_q[rd_ptr_q];
                grf_wd  = wd_q[rd_ptr_q];
                grf_pc  = pc_q[rd_ptr_q];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hazard queries: any live queued write to the register. $0 never hits.
    // ------------------------------------------------------------------------
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (adr_q[i] == q_adr1)) begin
                q_hit1 = 1'b1;
            end
            if (live_q[i] && (adr_q[i] == q_adr2)) begin
                q_hit2 = 1'b1;
            end
        end
        if (q_adr1 == 5'd0) begin
            q_hit1 = 1'b0;
        end
        if (q_adr2 == 5'd0) begin
            q_hit2 = 1'b0;
        end
    end

`ifdef GRF_WPORT_TRACE_EN
    always @(posedge clk) begin
        if (grf_we) begin
            $display("@%h: $%d <= %h", grf_pc, grf_adr, grf_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;

  localparam int DP = 4;
  localparam int SM = 8;

  // Aux entries offered at cycles 0..DP-1 fill the queue; the starve counter
  // reaches SM at the edge ending cycle SM, the stall flop sets one edge
  // later, so the pipeline is frozen for cycles SM+2 .. SM+2+DP-1.
  localparam int STALL_FIRST = SM + 2;
  localparam int STALL_LAST  = SM + 2 + DP - 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_adr;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_adr;
  logic [31:0] aux_wd;
  logic [31:0] aux_pc;
  logic [4:0]  q_adr1;
  logic [4:0]  q_adr2;
  logic        q_hit1;
  logic        q_hit2;
  logic        pipe_stall;
  logic        grf_we;
  logic [4:0]  grf_adr;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  always #5 clk = ~clk;

  grf_wport_arbiter #(.DEPTH(DP), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_adr(w_adr), .w_wd(w_wd), .w_pc(w_pc),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_adr(aux_adr), .aux_wd(aux_wd), .aux_pc(aux_pc),
    .q_adr1(q_adr1), .q_adr2(q_adr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .pipe_stall(pipe_stall),
    .grf_we(grf_we), .grf_adr(grf_adr), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];  // {adr, wd} of aux writes expected on the port

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_w(input logic we, input logic [4:0] adr, input logic [31:0] wd,
                         input logic [31:0] pc);
    w_we = we; w_adr = adr; w_wd = wd; w_pc = pc;
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] adr, input logic [31:0] wd,
                           input logic [31:0] pc);
    aux_valid = v; aux_adr = adr; aux_wd = wd; aux_pc = pc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w_we;
    logic [4:0]  w_adr;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        av;
    logic [4:0]  a_adr;
    logic [31:0] a_wd;
    logic [31:0] a_pc;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_adr;
    logic [31:0] e_wd;
    logic [31:0] e_pc;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic        e_stall;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    //          W: we adr  wd          pc           aux: v adr wd          pc           q1     q2     exp: we adr   wd          pc           rdy   h1    h2    stall
    // W write lands on the port in the same cycle
    vecs[0]  = '{1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0,    32'h0,    5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0};
    // aux $8 enqueued while W idle: not visible yet
    vecs[1]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd8, 32'hAA,   32'h3004, 5'd8, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    // head drains one cycle later, still hits until the pop
    vecs[2]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd8, 5'd0, 1'b1, 5'd8, 32'hAA,   32'h3004, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd8, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    // aux $9=1 enqueued while W busy on $3
    vecs[4]  = '{1'b1, 5'd3, 32'h33,   32'h300C, 1'b1, 5'd9, 32'h1,    32'h3008, 5'd9, 5'd0, 1'b1, 5'd3, 32'h33,   32'h300C, 1'b1, 1'b0, 1'b0, 1'b0};
    // W writes $9=2: port takes W, queued $9 is killed at this edge
    vecs[5]  = '{1'b1, 5'd9, 32'h2,    32'h3010, 1'b0, 5'd0, 32'h0,    32'h0,    5'd9, 5'd0, 1'b1, 5'd9, 32'h2,    32'h3010, 1'b1, 1'b1, 1'b0, 1'b0};
    // killed entry drains as a no-op
    vecs[6]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd9, 5'd0, 1'b0, 5'd9, 32'h1,    32'h3008, 1'b1, 1'b0, 1'b0, 1'b0};
    // W $9=4 and aux $9=5 at the same edge: aux is younger, survives
    vecs[7]  = '{1'b1, 5'd9, 32'h4,    32'h3014, 1'b1, 5'd9, 32'h5,    32'h3018, 5'd9, 5'd0, 1'b1, 5'd9, 32'h4,    32'h3014, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd9, 5'd0, 1'b1, 5'd9, 32'h5,    32'h3018, 1'b1, 1'b1, 1'b0, 1'b0};
    // aux write to $0: accepted, drains without a GRF write, $0 never hits
    vecs[9]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd0, 32'hDEAD, 32'h301C, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'hDEAD, 32'h301C, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    // W write to $0 is not an effective write
    vecs[12] = '{1'b1, 5'd0, 32'h55,   32'h3020, 1'b0, 5'd0, 32'h0,    32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    // q_hit2 path: aux $7 waits behind two W writes
    vecs[13] = '{1'b1, 5'd6, 32'h66,   32'h3024, 1'b1, 5'd7, 32'h77,   32'h3028, 5'd0, 5'd7, 1'b1, 5'd6, 32'h66,   32'h3024, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 5'd4, 32'h44,   32'h302C, 1'b0, 5'd0, 32'h0,    32'h0,    5'd6, 5'd7, 1'b1, 5'd4, 32'h44,   32'h302C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd0, 5'd7, 1'b1, 5'd7, 32'h77,   32'h3028, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    5'd0, 5'd7, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    drive_w(1'b1, 5'd5, 32'h77, 32'h10);  // active W during reset must not reach the port
    drive_aux(1'b0, 5'd0, 32'h0, 32'h0);
    q_adr1 = 5'd0; q_adr2 = 5'd0;

    @(negedge clk);
    chk("rst.grf_we", 64'(grf_we), 64'd0);
    chk("rst.grf_wd", 64'(grf_wd), 64'd0);
    chk("rst.grf_adr", 64'(grf_adr), 64'd0);
    chk("rst.pipe_stall", 64'(pipe_stall), 64'd0);
    @(posedge clk); #1;
    drive_w(1'b0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel.aux_ready", 64'(aux_ready), 64'd1);
    chk("rel.grf_we", 64'(grf_we), 64'd0);
    next_cycle();

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      drive_w(vecs[i].w_we, vecs[i].w_adr, vecs[i].w_wd, vecs[i].w_pc);
      drive_aux(vecs[i].av, vecs[i].a_adr, vecs[i].a_wd, vecs[i].a_pc);
      q_adr1 = vecs[i].q1;
      q_adr2 = vecs[i].q2;
      @(negedge clk);
      chk($sformatf("v%0d.grf_we", i), 64'(grf_we), 64'(vecs[i].e_we));
      chk($sformatf("v%0d.grf_adr", i), 64'(grf_adr), 64'(vecs[i].e_adr));
      chk($sformatf("v%0d.grf_wd", i), 64'(grf_wd), 64'(vecs[i].e_wd));
      chk($sformatf("v%0d.grf_pc", i), 64'(grf_pc), 64'(vecs[i].e_pc));
      chk($sformatf("v%0d.aux_ready", i), 64'(aux_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d.q_hit1", i), 64'(q_hit1), 64'(vecs[i].e_h1));
      chk($sformatf("v%0d.q_hit2", i), 64'(q_hit2), 64'(vecs[i].e_h2));
      chk($sformatf("v%0d.pipe_stall", i), 64'(pipe_stall), 64'(vecs[i].e_stall));
      next_cycle();
    end
    drive_aux(1'b0, 5'd0, 32'h0, 32'h0);

    // ---- starvation: fill the queue while W writes every cycle ----
    q_adr1 = 5'd10;
    q_adr2 = 5'(10 + DP - 1);
    for (int c = 0; c < STALL_LAST + 3; c++) begin
      logic exp_stall;
      logic [36:0] exp_ent;
      drive_w(1'b1, 5'd2, 32'h1000 + 32'(c), 32'h4000 + 32'(4 * c));
      if (c < DP) begin
        drive_aux(1'b1, 5'(10 + c), 32'hA0 + 32'(c), 32'h5000 + 32'(4 * c));
        exp_q.push_back({5'(10 + c), 32'hA0 + 32'(c)});
      end else begin
        drive_aux(1'b0, 5'd0, 32'h0, 32'h0);
      end
      exp_stall = (c >= STALL_FIRST) && (c <= STALL_LAST);
      @(negedge clk);
      chk($sformatf("st%0d.pipe_stall", c), 64'(pipe_stall), 64'(exp_stall));
      chk($sformatf("st%0d.aux_ready", c), 64'(aux_ready), 64'(!(c >= DP && c <= STALL_FIRST)));
      chk($sformatf("st%0d.q_hit1", c), 64'(q_hit1), 64'(c >= 1 && c <= STALL_FIRST));
      chk($sformatf("st%0d.q_hit2", c), 64'(q_hit2), 64'(c >= DP && c <= STALL_LAST));
      chk($sformatf("st%0d.grf_we", c), 64'(grf_we), 64'd1);
      if (exp_stall) begin
        if (exp_q.size() > 0) exp_ent = exp_q.pop_front();
        else exp_ent = '1;
        chk($sformatf("st%0d.aux_port", c), 64'({grf_adr, grf_wd}), 64'(exp_ent));
      end else begin
        chk($sformatf("st%0d.w_port", c), 64'({grf_adr, grf_wd}),
            64'({5'd2, 32'h1000 + 32'(c)}));
      end
      next_cycle();
    end
    drive_w(1'b0, 5'd0, 32'h0, 32'h0);
    chk("st.exp_q_drained", 64'(exp_q.size()), 64'd0);
    q_adr1 = 5'd0; q_adr2 = 5'd0;
    next_cycle();

    // ---- reset mid-drain ----
    for (int c = 0; c < 3; c++) begin
      drive_w(1'b1, 5'd3, 32'hB0 + 32'(c), 32'h6000 + 32'(4 * c));
      drive_aux(1'b1, 5'(20 + c), 32'hC0 + 32'(c), 32'h7000 + 32'(4 * c));
      next_cycle();
    end
    drive_w(1'b0, 5'd0, 32'h0, 32'h0);
    drive_aux(1'b0, 5'd0, 32'h0, 32'h0);
    q_adr1 = 5'd22;
    @(negedge clk);
    chk("rm.drain0", 64'({grf_we, grf_adr, grf_wd}), 64'({1'b1, 5'd20, 32'hC0}));
    next_cycle();
    #2;
    chk("rm.drain1", 64'({grf_we, grf_adr, grf_wd}), 64'({1'b1, 5'd21, 32'hC1}));
    chk("rm.hit_before", 64'(q_hit1), 64'd1);
    drive_w(1'b1, 5'd5, 32'h99, 32'h8000);
    reset = 1'b0;
    #1;
    chk("rm.async_we", 64'(grf_we), 64'd0);
    chk("rm.async_out", 64'({grf_adr, grf_wd, grf_pc}), 64'd0);
    chk("rm.async_hit", 64'(q_hit1), 64'd0);
    chk("rm.async_stall", 64'(pipe_stall), 64'd0);
    @(negedge clk);
    drive_w(1'b0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rm.post%0d.grf_we", c), 64'(grf_we), 64'd0);
      chk($sformatf("rm.post%0d.q_hit1", c), 64'(q_hit1), 64'd0);
      chk($sformatf("rm.post%0d.aux_ready", c), 64'(aux_ready), 64'd1);
      next_cycle();
    end

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
